imm_decode_buffer: RTL and testbench
====================================

Name: imm_decode_buffer

Overview:
- Decode-side stage directly upstream of the immediate sign/zero extender.
- Accepts 16-bit instructions from fetch over a valid/ready handshake and buffers them in a 2-entry skid buffer.
- For each buffered instruction, presents the split fields: opcode, rdest, opExt, rsrc and the 8-bit immediate.
- Also presents the signExtImm and useImm controls that the extender and the ALU B-operand mux consume.

Parameters:
- None. ISA widths are fixed: 16-bit instruction, 8-bit immediate, 4-bit fields.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- flush  input  1  synchronous discard of all buffered instructions (branch/jump redirect)
- inValid  input  1  fetch presents an instruction
- instr  input  16  instruction word: [15:12] opcode, [11:8] rdest, [7:4] opExt, [3:0] rsrc, [7:0] immediate
- inReady  output  1  buffer can accept an instruction this cycle
- outValid  output  1  head entry holds a valid decoded instruction
- outReady  input  1  downstream consumes the head entry this cycle
- opcode  output  4  head instr[15:12]
- rdest  output  4  head instr[11:8]
- opExt  output  4  head instr[7:4]
- rsrc  output  4  head instr[3:0]
- immediate  output  8  head instr[7:0]; feeds the extender immediate input
- signExtImm  output  1  1 = sign-extend, 0 = zero-extend; feeds the extender
- useImm  output  1  1 = ALU B operand comes from the extended immediate

Behaviour:
- Clocking and reset:
  - One clock domain.
  - reset is synchronous and active-high, sampled on the rising edge of clk.
- Storage:
  - Two entries, each holding the raw 16-bit instruction plus the precomputed signExtImm and useImm bits.
  - Head pointer, tail pointer and count (0..2) are all registered.
- Decode, done on push (combinational from instr, registered into the entry):
  - useImm = 1 for opcodes 0001, 0010, 0011, 0101, 0110, 0111, 1001, 1011, 1101, 1111.
  - useImm = 0 otherwise (0000 register-register, 0100 load/store/jump, 1000 shift, 1010, 1100, 1110).
  - signExtImm = 1 for opcodes 0101 ADDI, 0111 ADDCI, 1001 SUBI, 1011 CMPI.
  - signExtImm = 0 for every other opcode, including MOVI 1101, LUI 1111 and the logical immediates.
- Handshake:
  - inReady = (count != 2), derived only from registered state; there is no combinational path from outReady.
  - push = inValid & inReady; pop = outValid & outReady.
  - outValid = (count != 0).
  - All field outputs come from the head entry.
  - When count == 0, all field outputs and both controls are driven to 0.
- Latency:
  - An instruction pushed at edge N is visible on the outputs in cycle N+1 when the buffer was empty or its entry becomes head.
  - No combinational instr-to-output path.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged. The head advances and the new entry is written at the tail.
- Order: FIFO; entries leave in acceptance order.
- Pointers: 1-bit head and tail pointers toggle on wrap.
- Boundary conditions:
  - count == 2: inReady = 0; inValid is ignored and instr is not sampled.
  - count == 0 with outReady = 1: no pop; state unchanged.
  - A held outValid with outReady = 0 keeps all outputs stable every cycle until consumed.
- Flush:
  - flush = 1 at edge N sets count to 0 and both pointers to 0.
  - flush has priority over a simultaneous push and pop: the incoming instruction is dropped, and the head counts as not consumed.
  - outValid = 0 in cycle N+1.
- Reset:
  - reset has priority over flush.
  - Sets count, pointers and entries to 0.
  - After reset: outValid = 0, inReady = 1, all field outputs 0.
  - Reset mid-operation discards all buffered instructions identically.

Test Plan:
- Reset, then idle: outValid = 0, inReady = 1, immediate = 8'h00, signExtImm = 0, useImm = 0.
- Push ADDI instr = 16'h5A_F3 with outReady = 1: next cycle outValid = 1, opcode = 5, rdest = A, immediate = 8'hF3, signExtImm = 1, useImm = 1; entry popped on that edge.
- Push ORI 16'h2_3_80 then SUB reg-reg 16'h0_1_9_2 with outReady = 0: after 2 pushes inReady = 0 and a third instr is not accepted. ORI head shows immediate = 8'h80, signExtImm = 0, useImm = 1 and is held stable. Raising outReady pops ORI, then SUB with useImm = 0.
- count = 1 with simultaneous push and pop over 10 consecutive cycles of distinct instructions: count stays 1, outValid stays 1, and outputs follow input order with one-cycle lag.
- flush asserted together with inValid at count = 2: next cycle outValid = 0, inReady = 1, and the flushed instructions never appear on the outputs.
- reset asserted with count = 2 and flush = 1 in the same cycle: next cycle all outputs match the reset state. A subsequent push of CMPI 16'hB1_FF yields immediate = 8'hFF, signExtImm = 1.

Source files
------------

// File: rtl/imm_decode_buffer_if.sv
// Fetch-to-decode handshake and decoded-field bus for imm_decode_buffer.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. Once asserted, a valid stays high and its payload stays stable
// until that transfer. A ready may change freely, but it never depends
// combinationally on the matching valid.
interface imm_decode_buffer_if;
    // Fetch side
    logic        inValid;
    logic [15:0] instr;
    logic        inReady;
    // Decode/extender side
    logic        outValid;
    logic        outReady;
    logic [3:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  opExt;
    logic [3:0]  rsrc;
    logic [7:0]  immediate;
    logic        signExtImm;
    logic        useImm;

    // Buffer side
    modport slave (
        input  inValid, instr, outReady,
        output inReady, outValid, opcode, rdest, opExt, rsrc,
               immediate, signExtImm, useImm
    );

    // Environment side: fetch producer plus downstream consumer
    modport master (
        output inValid, instr, outReady,
        input  inReady, outValid, opcode, rdest, opExt, rsrc,
               immediate, signExtImm, useImm
    );
endinterface

// File: rtl/imm_decode_buffer.sv
// Two-entry skid buffer between fetch and the immediate extender.
// The immediate controls are decoded as each instruction is accepted and
// stored with it. The outputs are therefore driven only from registered
// state, and there is no combinational path from instr to any output.
module imm_decode_buffer (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    imm_decode_buffer_if.slave    bus
);

    logic [15:0] entry_instr [2];
    logic        entry_sext  [2];
    logic        entry_use   [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        push;
    logic        pop;
    logic        dec_use;
    logic        dec_sext;

    // Accept only when not full; ready depends on count alone.
    assign bus.inReady  = (count != 2'd2);
    assign bus.outValid = (count != 2'd0);
    assign push = bus.inValid & bus.inReady;
    assign pop  = bus.outValid & bus.outReady;

    // Immediate-usage decode of the incoming opcode.
    always_comb begin
        dec_use  = 1'b0;
        dec_sext = 1'b0;
        case (bus.instr[15:12])
            4'b0001, 4'b0010, 4'b0011, 4'b0110,
            4'b1101, 4'b1111:                    dec_use = 1'b1;
            4'b0101, 4'b0111, 4'b1001, 4'b1011: begin
                dec_use  = 1'b1;
                dec_sext = 1'b1;
            end
            default: begin
                dec_use  = 1'b0;
                dec_sext = 1'b0;
            end
        endcase
    end

    // Storage, pointers and occupancy. Reset beats flush, and flush beats
    // any push or pop in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                entry_instr[i] <= 16'h0000;
                entry_sext[i]  <= 1'b0;
                entry_use[i]   <= 1'b0;
            end
        end else if (flush) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                entry_instr[tail] <= bus.instr;
                entry_sext[tail]  <= dec_sext;
                entry_use[tail]   <= dec_use;
                tail              <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Present the head entry, or all zeros when the buffer is empty.
    always_comb begin
        bus.opcode     = 4'h0;
        bus.rdest      = 4'h0;
        bus.opExt      = 4'h0;
        bus.rsrc       = 4'h0;
        bus.immediate  = 8'h00;
        bus.signExtImm = 1'b0;
        bus.useImm     = 1'b0;
        if (count != 2'd0) begin
            bus.opcode     = entry_instr[head][15:12];
            bus.rdest      = entry_instr[head][11:8];
            bus.opExt      = entry_instr[head][7:4];
            bus.rsrc       = entry_instr[head][3:0];
            bus.immediate  = entry_instr[head][7:0];
            bus.signExtImm = entry_sext[head];
            bus.useImm     = entry_use[head];
        end
    end

endmodule

// File: tb/tb_imm_decode_buffer.sv
// Directed bench for imm_decode_buffer: inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_imm_decode_buffer;

    logic clk;
    logic reset;
    logic flush;
    int   checks;
    int   errors;

    imm_decode_buffer_if bus ();

    imm_decode_buffer dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [15:0] ins,
                              input logic sext, input logic use_imm);
        check({tag, " outValid"}, 16'(bus.outValid), 16'h1);
        check({tag, " fields"}, {bus.opcode, bus.rdest, bus.opExt, bus.rsrc}, ins);
        check({tag, " immediate"}, 16'(bus.immediate), 16'(ins[7:0]));
        check({tag, " signExtImm"}, 16'(bus.signExtImm), 16'(sext));
        check({tag, " useImm"}, 16'(bus.useImm), 16'(use_imm));
    endtask

    task automatic check_empty(input string tag);
        check({tag, " outValid"}, 16'(bus.outValid), 16'h0);
        check({tag, " inReady"}, 16'(bus.inReady), 16'h1);
        check({tag, " fields"}, {bus.opcode, bus.rdest, bus.opExt, bus.rsrc}, 16'h0000);
        check({tag, " immediate"}, 16'(bus.immediate), 16'h0000);
        check({tag, " ctrl"}, {14'h0, bus.signExtImm, bus.useImm}, 16'h0000);
    endtask

    logic [15:0] vec      [10];
    logic        exp_sext [10];
    logic        exp_use  [10];

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        flush  = 1'b0;
        bus.inValid  = 1'b0;
        bus.instr    = 16'h0000;
        bus.outReady = 1'b0;

        // Streaming table: instruction, hand-decoded sext/use
        vec[0] = 16'h0123; exp_sext[0] = 0; exp_use[0] = 0;
        vec[1] = 16'h1A45; exp_sext[1] = 0; exp_use[1] = 1;
        vec[2] = 16'h2B67; exp_sext[2] = 0; exp_use[2] = 1;
        vec[3] = 16'h3C89; exp_sext[3] = 0; exp_use[3] = 1;
        vec[4] = 16'h4DAB; exp_sext[4] = 0; exp_use[4] = 0;
        vec[5] = 16'h5ECD; exp_sext[5] = 1; exp_use[5] = 1;
        vec[6] = 16'h6FEF; exp_sext[6] = 0; exp_use[6] = 1;
        vec[7] = 16'h7012; exp_sext[7] = 1; exp_use[7] = 1;
        vec[8] = 16'h8134; exp_sext[8] = 0; exp_use[8] = 0;
        vec[9] = 16'h9256; exp_sext[9] = 1; exp_use[9] = 1;

        // Reset, then idle
        step();
        step();
        reset = 1'b0;
        step();
        check_empty("reset");

        // ADDI pushed and popped straight through
        bus.inValid = 1'b1; bus.instr = 16'h5AF3; bus.outReady = 1'b1;
        step();
        bus.inValid = 1'b0;
        check_head("addi", 16'h5AF3, 1'b1, 1'b1);
        step();
        check("addi popped", 16'(bus.outValid), 16'h0);

        // Fill with ORI then SUB while downstream stalls
        bus.outReady = 1'b0;
        bus.inValid = 1'b1; bus.instr = 16'h2380;
        step();
        check("one entry inReady", 16'(bus.inReady), 16'h1);
        bus.instr = 16'h0192;
        step();
        check("full inReady", 16'(bus.inReady), 16'h0);
        check_head("ori head", 16'h2380, 1'b0, 1'b1);
        bus.instr = 16'hF0F0;
        step();
        check("full ignore inReady", 16'(bus.inReady), 16'h0);
        check_head("ori held 1", 16'h2380, 1'b0, 1'b1);
        step();
        check_head("ori held 2", 16'h2380, 1'b0, 1'b1);
        bus.inValid = 1'b0;
        bus.outReady = 1'b1;
        step();
        check_head("sub head", 16'h0192, 1'b0, 1'b0);
        check("sub inReady", 16'(bus.inReady), 16'h1);
        step();
        check_empty("drained");

        // count = 1 with simultaneous push/pop each cycle
        bus.outReady = 1'b0;
        bus.inValid = 1'b1; bus.instr = 16'hE000;
        step();
        check_head("stream prime", 16'hE000, 1'b0, 1'b0);
        bus.outReady = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.instr = vec[i];
            step();
            check_head($sformatf("stream %0d", i), vec[i], exp_sext[i], exp_use[i]);
            check($sformatf("stream %0d inReady", i), 16'(bus.inReady), 16'h1);
        end
        bus.inValid = 1'b0;
        step();
        check_empty("stream end");

        // Flush at count = 2 with a push and pop pending
        bus.outReady = 1'b0;
        bus.inValid = 1'b1; bus.instr = 16'hD123;
        step();
        bus.instr = 16'hF456;
        step();
        check("pre-flush inReady", 16'(bus.inReady), 16'h0);
        check_head("pre-flush head", 16'hD123, 1'b0, 1'b1);
        flush = 1'b1; bus.instr = 16'hC789; bus.outReady = 1'b1;
        step();
        flush = 1'b0; bus.inValid = 1'b0; bus.outReady = 1'b0;
        check_empty("flush");
        step();
        check_empty("flush hold");
        bus.inValid = 1'b1; bus.instr = 16'hCABC;
        step();
        bus.inValid = 1'b0;
        check_head("after flush", 16'hCABC, 1'b0, 1'b0);
        bus.outReady = 1'b1;
        step();
        check_empty("after flush pop");
        bus.outReady = 1'b0;

        // Reset with flush at count = 2
        bus.inValid = 1'b1; bus.instr = 16'h1111;
        step();
        bus.instr = 16'h2222;
        step();
        check("pre-reset inReady", 16'(bus.inReady), 16'h0);
        reset = 1'b1; flush = 1'b1; bus.instr = 16'h3333;
        step();
        reset = 1'b0; flush = 1'b0; bus.inValid = 1'b0;
        check_empty("mid reset");
        bus.inValid = 1'b1; bus.instr = 16'hB1FF;
        step();
        bus.inValid = 1'b0;
        check_head("cmpi", 16'hB1FF, 1'b1, 1'b1);
        bus.outReady = 1'b1;
        step();
        check_empty("cmpi popped");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
